imem_loader: RTL
================

# imem_loader

Boot-time writer for the instruction memory. It receives a byte stream from the debug/UART link using a valid/ready handshake and assembles it into little-endian 32-bit words. It writes those words into the instruction memory write port at consecutive word addresses and holds the CPU in reset until the full image is loaded. It sits between the serial receiver and the instruction memory, and owns the CPU hold line.

## Interface
- `DEPTH_WORDS`, default 4096: instruction memory capacity in 32-bit words; maximum accepted image length.
- `BASE_ADDR`, default 0: byte address of the first word written.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-low (0 = reset, sampled on the `clk` edge).
- `start`, in, 1: one-cycle load request; ignored while busy.
- `byte_valid`, in, 1: `byte_data` is valid.
- `byte_data`, in, 8: stream byte.
- `byte_ready`, out, 1: loader accepts a byte this cycle.
- `imem_we`, out, 1: instruction memory write enable, one cycle per word.
- `imem_addr`, out, ALEN: byte address of the write, word aligned.
- `imem_wdata`, out, 32: word to write.
- `cpu_hold`, out, 1: keeps the core in reset while 1.
- `busy`, out, 1: load in progress.
- `done`, out, 1: image loaded successfully (level).
- `error`, out, 1: load aborted (level).

## Operation
- A byte is accepted on a rising edge with `byte_valid && byte_ready`.
- States:
  - IDLE
  - HDR: 4 bytes, the word count N, little-endian.
  - LOAD: 4 bytes per word.
  - WRITE
  - CSUM: only with the macro in Configuration.
  - DONE
  - ERROR
- IDLE:
  - `start` moves to HDR and clears the byte index, word index and running sum.
- HDR, after the 4th byte:
  - N == 0: go to DONE.
  - N > `DEPTH_WORDS`: go to ERROR.
  - Otherwise: go to LOAD.
- LOAD:
  - Byte k (0..3) goes to bits [8k+7:8k].
  - After the 4th byte, go to WRITE.
- WRITE, lasts exactly one cycle:
  - `imem_we`=1, `imem_addr` = `BASE_ADDR` + 4·idx (ALEN-bit, wraps mod 2^ALEN), `imem_wdata` = assembled word.
  - idx increments and the word is added to the 32-bit running sum, mod 2^32.
  - If idx+1 == N, go to CSUM (macro on) or DONE. Otherwise return to LOAD.
- DONE:
  - `done`=1, `cpu_hold`=0.
  - `start` restarts the load: go to HDR, `done`←0, `cpu_hold`←1.
- ERROR:
  - `error`=1, `cpu_hold`=1.
  - `start` restarts the load: go to HDR, `error`←0.
  - Once in ERROR, no further `imem_we`.
- `byte_ready`=1 only in HDR, LOAD and CSUM. It is 0 in IDLE, WRITE, DONE and ERROR.
- `busy`=1 in HDR, LOAD, WRITE and CSUM.
- `start` is ignored in HDR, LOAD, WRITE and CSUM.
- Gaps in `byte_valid` stall the loader indefinitely with no timeout, and the partial word is kept.

## Timing
- Reset values:
  - State IDLE, `cpu_hold`=1.
  - `byte_ready`, `imem_we`, `busy`, `done`, `error` all 0.
  - `imem_addr`=`BASE_ADDR`, `imem_wdata`=0.
  - Internal counters 0.
- `start` sampled in cycle t: `busy`=1 and `byte_ready`=1 from cycle t+1.
- 4th byte of a word accepted at edge t: `imem_we` high during cycle t+1 only, `byte_ready`=0 that cycle.
- Minimum 5 cycles per word with `byte_valid` held high.
- Last WRITE in cycle t (macro off): `done`=1 and `cpu_hold`=0 from cycle t+1.
- `rst` low mid-load: next edge returns all outputs to reset values. A write already committed stays in memory. No write is issued after reset.
- All outputs are registered.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the N words, CSUM accepts 4 more bytes, C, little-endian.
  - If (sum + C) mod 2^32 == 0, go to DONE. Otherwise go to ERROR.
  - The checksum does not apply when N == 0.
- Undefined:
  - There is no CSUM state.
  - Go to DONE directly after the last WRITE.

## Test plan
- Reset check: hold `rst`=0 for 2 cycles, then release → `cpu_hold`=1, `byte_ready`=0, `imem_we`=0, `done`=0, `error`=0.
- Basic load: `start`, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 → writes (0x0, 0x00000013), then (0x4, 0x00100093), each with a 1-cycle `imem_we`. `done`=1 and `cpu_hold`=0 the cycle after the second write.
- Zero length: header 00 00 00 00 → DONE, no `imem_we`, `cpu_hold`=0.
- Oversize: `DEPTH_WORDS`=4, header 05 00 00 00 → ERROR, `error`=1, `cpu_hold`=1, no writes. A following `start` clears `error` and re-enters HDR.
- Backpressure and stall: random `byte_valid` gaps, `start` pulsed mid-load → identical writes, `start` ignored. `rst`=0 after 1 of 3 words → outputs return to reset values and no further writes.
- Checksum, macro on: N=1, word 0x00000013.
  - Checksum FFFFFFED → DONE.
  - Checksum FFFFFFEE → ERROR.
  - In both cases exactly one write occurs, before the checksum is checked.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader: streams a length-prefixed little-endian byte image into the   |
// | instruction memory and holds the CPU in reset until it is loaded.          |
// | Optional trailing checksum stage: LOADER_CHECKSUM_EN.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_loader #(
  parameter int              DEPTH_WORDS = 4096,
  parameter int              ALEN        = 32,
  parameter logic [ALEN-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            imem_we,
  output logic [ALEN-1:0] imem_addr,
  output logic [31:0]     imem_wdata,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_bidx;
  logic [31:0]     r_word;
  logic [31:0]     r_count;
  logic [31:0]     r_idx;
  logic [31:0]     r_sum;
  logic            r_byte_ready;
  logic            r_imem_we;
  logic [ALEN-1:0] r_imem_addr;
  logic [31:0]     r_imem_wdata;
  logic            r_cpu_hold;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  logic            w_accept;
  logic            w_last_byte;
  logic [31:0]     w_word;
  logic            w_restart;
  logic            w_next_ready;

  // The word being assembled, including the byte accepted this cycle.
  assign w_word      = {byte_data, r_word[31:8]};
  assign w_accept    = byte_valid && r_byte_ready;
  assign w_last_byte = w_accept && (r_bidx == 2'd3);
  assign w_restart   = (w_next == S_HDR) && (r_state != S_HDR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_HDR;
      end
      S_HDR: begin
        if (w_last_byte) begin
          if (w_word == 32'd0)        w_next = S_DONE;
          else if (w_word > c_depth)  w_next = S_ERROR;
          else                        w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_last_byte) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (r_idx + 32'd1 == r_count) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_last_byte) begin
          if (r_sum + w_word == 32'd0) w_next = S_DONE;
          else                         w_next = S_ERROR;
        end
      end
`endif
      S_DONE, S_ERROR: begin
        if (start) w_next = S_HDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_next_ready = 1'b0;
    case (w_next)
      S_HDR, S_LOAD: w_next_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:        w_next_ready = 1'b1;
`endif
      default:       w_next_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_bidx       <= 2'd0;
      r_word       <= 32'd0;
      r_count      <= 32'd0;
      r_idx        <= 32'd0;
      r_sum        <= 32'd0;
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= BASE_ADDR;
      r_imem_wdata <= 32'd0;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next;
      // Outputs are registered from the next state so they line up with it.
      r_byte_ready <= w_next_ready;
      r_imem_we    <= (w_next == S_WRITE);
      r_busy       <= w_next_ready || (w_next == S_WRITE);
      r_cpu_hold   <= (w_next != S_DONE);
      r_done       <= (w_next == S_DONE);
      r_error      <= (w_next == S_ERROR);

      if (w_restart) begin
        r_bidx <= 2'd0;
        r_idx  <= 32'd0;
        r_sum  <= 32'd0;
      end else if (w_accept) begin
        r_bidx <= r_bidx + 2'd1;
        r_word <= w_word;
      end

      if (r_state == S_HDR && w_last_byte) r_count <= w_word;

      if (r_state == S_LOAD && w_last_byte) begin
        r_imem_addr  <= BASE_ADDR + ALEN'({r_idx, 2'b00});
        r_imem_wdata <= w_word;
      end

      if (r_state == S_WRITE) begin
        r_idx <= r_idx + 32'd1;
        r_sum <= r_sum + r_imem_wdata;
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule
`default_nettype wire
